// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline.
//   state_t   : pipeline sequencing state (run / drain after HALT / frozen)
//   REG_ZERO  : register $zero; never a real load-use producer
//   OP_*      : primary opcodes that the ID decoder matches for jump/halt
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_HALT = 6'h3F;

endpackage

// File: rtl/step_sync_edge.sv
// Synchronizes the asynchronous step button and emits a one-clock pulse on
// each synchronized 0->1 transition.
//   clk, rst_n : clock and synchronous active-low reset
//   btn        : debounced button, asynchronous to clk
//   pulse      : one-clock step request
module step_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  // fill marks which synchronizer flops hold real samples rather than reset
  // zeros; prev is only allowed to follow the chain once it is full, so a
  // button held through reset is never mistaken for a fresh press.
  logic [SYNC_STAGES-1:0] fill;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      fill <= '0;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      if (fill[SYNC_STAGES-1]) prev <= sync[SYNC_STAGES-1];
    end
  end

  assign pulse = fill[SYNC_STAGES-1] & sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/pipe_hazard_step_ctrl.sv
// Sequencing and hazard controller for the 5-stage MIPS pipeline.
// Produces the global advance enable (free-run or single-step), the PC and
// IF/ID write enables, the IF/ID and ID/EX flushes for load-use stalls,
// jumps, taken branches and HALT drain, plus debug cycle/stall counters.
//   clk, rst_n          : clock, synchronous active-low reset
//   mode_step, btn_step : single-step mode select and raw step button
//   id_* / ex_*         : decode info from ID and EX stages
//   adv                 : global stage enable
//   pc_we, ifid_we      : PC and IF/ID write enables
//   ifid_flush          : IF/ID loads NOP
//   idex_flush          : ID/EX loads bubble
//   halted              : pipeline frozen after HALT retired
//   cycle_cnt           : advances since reset (wraps)
//   stall_cnt           : load-use stall advances since reset (saturates)
module pipe_hazard_step_ctrl
  import mips_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32,
  parameter int STALL_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_step,
  input  logic               btn_step,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic               id_is_jump,
  input  logic               id_is_halt,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rt,
  input  logic               ex_branch_taken,
  output logic               adv,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int               DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + STALL_W'(1);
  endfunction

  state_t           state, state_nxt;
  logic [DRN_W-1:0] drain_cnt, drain_nxt;
  logic             step_pulse;
  logic             go;
  logic             luh;
  logic             stall_inc;

  step_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_step),
    .pulse (step_pulse)
  );

  assign go  = mode_step ? step_pulse : 1'b1;
  assign luh = ex_mem_read & (ex_rt != REG_ZERO) &
               ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    adv        = 1'b0;
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    stall_inc  = 1'b0;
    if (rst_n) begin
      case (state)
        ST_RUN: begin
          adv = go;
          if (go) begin
            if (ex_branch_taken) begin
              pc_we      = 1'b1;
              ifid_we    = 1'b1;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (luh) begin
              idex_flush = 1'b1;
              stall_inc  = 1'b1;
            end else if (id_is_jump) begin
              pc_we      = 1'b1;
              ifid_we    = 1'b1;
              ifid_flush = 1'b1;
            end else if (!id_is_halt) begin
              pc_we   = 1'b1;
              ifid_we = 1'b1;
            end
            // A HALT squashed by a taken branch never really issued.
            if (id_is_halt && !ex_branch_taken) begin
              state_nxt = ST_DRAIN;
              drain_nxt = '0;
            end
          end
        end
        ST_DRAIN: begin
          adv = go;
          if (go) begin
            idex_flush = 1'b1;
            if (drain_cnt == DRN_LAST) state_nxt = ST_HALTED;
            else                       drain_nxt = drain_cnt + DRN_W'(1);
          end
        end
        ST_HALTED: halted = 1'b1;
        default:   state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (adv)       cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_step_ctrl.sv
module tb_pipe_hazard_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_step;
  logic        btn_step;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_is_jump, id_is_halt, ex_mem_read, ex_branch_taken;
  logic        adv, pc_we, ifid_we, ifid_flush, idex_flush, halted;
  logic [31:0] cycle_cnt;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_step_ctrl #(
    .SYNC_STAGES(2), .DRAIN_CYCLES(3), .CNT_W(32), .STALL_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_step(mode_step), .btn_step(btn_step),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_jump(id_is_jump), .id_is_halt(id_is_halt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .adv(adv), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halted(halted),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {adv, pc_we, ifid_we, ifid_flush, idex_flush}
  function automatic logic [31:0] flags();
    return {27'd0, adv, pc_we, ifid_we, ifid_flush, idex_flush};
  endfunction

  // Advance to just after the next rising edge; inputs change here and
  // combinational outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_is_jump = 1'b0; id_is_halt = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic do_reset(input logic btn);
    rst_n = 1'b0; btn_step = btn;
    clear_hazards();
    tick(); tick();
  endtask

  initial begin
    int exp_cyc;
    int pulses, adv_cycles, first_edge, base;
    logic prev_adv;

    mode_step = 1'b0;
    do_reset(1'b0);

    // Reset state and outputs held low during reset
    #1;
    check("rst_flags", flags(), 32'b00000);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_stall", {16'd0, stall_cnt}, 32'd0);

    // Free run, no hazards, 10 clocks
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("free_flags", flags(), 32'b11100);
      tick();
    end
    exp_cyc = 10;
    check("free_cycle", cycle_cnt, exp_cyc);

    // Load-use on rs
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    check("luh_rs_flags", flags(), 32'b10001);
    tick(); exp_cyc++;
    check("luh_rs_stall", {16'd0, stall_cnt}, 32'd1);

    // Load to $zero: no stall
    ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    check("luh_zero_flags", flags(), 32'b11100);
    tick(); exp_cyc++;
    check("luh_zero_stall", {16'd0, stall_cnt}, 32'd1);

    // Load-use via rt only when rt is a source
    ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    check("rt_unused_flags", flags(), 32'b11100);
    id_uses_rt = 1'b1;
    #1;
    check("luh_rt_flags", flags(), 32'b10001);
    tick(); exp_cyc++;
    check("luh_rt_stall", {16'd0, stall_cnt}, 32'd2);

    // Branch taken overrides load-use
    ex_branch_taken = 1'b1;
    #1;
    check("br_luh_flags", flags(), 32'b11111);
    tick(); exp_cyc++;
    check("br_luh_stall", {16'd0, stall_cnt}, 32'd2);

    // Jump with load-use: stall wins; jump alone: flush IF/ID
    ex_branch_taken = 1'b0; id_is_jump = 1'b1;
    #1;
    check("jmp_luh_flags", flags(), 32'b10001);
    clear_hazards(); id_is_jump = 1'b1;
    #1;
    check("jmp_flags", flags(), 32'b11110);
    tick(); exp_cyc++;
    clear_hazards();
    check("jmp_stall", {16'd0, stall_cnt}, 32'd2);
    check("mid_cycle", cycle_cnt, exp_cyc);

    // Step mode: idle, then press 20, release 5, press 10
    mode_step = 1'b1;
    #1;
    check("step_idle_adv", {31'd0, adv}, 32'd0);
    base = exp_cyc;
    pulses = 0; adv_cycles = 0; first_edge = -1; prev_adv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      btn_step = (i < 20) || (i >= 25 && i < 35);
      #1;
      if (adv) adv_cycles++;
      if (adv && !prev_adv) pulses++;
      prev_adv = adv;
      tick();
      if (first_edge < 0 && cycle_cnt == base + 1) first_edge = i + 1;
    end
    btn_step = 1'b0;
    check("step_pulses", pulses, 32'd2);
    check("step_adv_cycles", adv_cycles, 32'd2);
    check("step_latency", first_edge, 32'd3);
    exp_cyc += 2;
    check("step_cycle", cycle_cnt, exp_cyc);

    // Button held through reset release: no step
    do_reset(1'b1);
    rst_n = 1'b1;
    adv_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (adv) adv_cycles++;
      tick();
    end
    check("held_rst_adv", adv_cycles, 32'd0);
    check("held_rst_cycle", cycle_cnt, 32'd0);
    btn_step = 1'b0;

    // HALT: branch+halt stays RUN, then real HALT drains 3, then frozen
    mode_step = 1'b0;
    id_is_halt = 1'b1; ex_branch_taken = 1'b1;
    #1;
    check("br_halt_flags", flags(), 32'b11111);
    tick();
    clear_hazards();
    #1;
    check("br_halt_run", flags(), 32'b11100);
    tick();
    id_is_halt = 1'b1;
    #1;
    check("halt_flags", flags(), 32'b10000);
    tick();
    clear_hazards();
    for (int i = 0; i < 3; i++) begin
      ex_branch_taken = 1'b1; id_is_jump = 1'b1;
      #1;
      check("drain_flags", flags(), 32'b10001);
      check("drain_halted", {31'd0, halted}, 32'd0);
      tick();
    end
    clear_hazards();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("halted_flags", flags(), 32'b00000);
      check("halted_flag", {31'd0, halted}, 32'd1);
      tick();
    end
    check("halted_cycle", cycle_cnt, 32'd6);

    // Reset mid-DRAIN
    do_reset(1'b0);
    rst_n = 1'b1;
    tick(); tick();
    id_is_halt = 1'b1;
    #1;
    check("halt2_flags", flags(), 32'b10000);
    tick();
    clear_hazards();
    tick();
    rst_n = 1'b0;
    #1;
    check("drain_rst_flags", flags(), 32'b00000);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_flags", flags(), 32'b11100);
    check("post_rst_halted", {31'd0, halted}, 32'd0);
    check("post_rst_cycle", cycle_cnt, 32'd0);
    check("post_rst_stall", {16'd0, stall_cnt}, 32'd0);
    tick();
    check("post_rst_run", cycle_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
